// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, matrix key map and scan FSM states.
// The calculator core imports the same key code constants.
package keypad_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_CLR   = 4'hE;
  localparam logic [3:0] KEY_DP    = 4'hF;

  // Nibble {row,col} holds the code; row0 = 1 2 3 A ... row3 = F 0 E D
  localparam logic [63:0] KEYMAP = 64'hDE0F_C987_B654_A321;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_RELEASE
  } kp_state_e;

  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] n;
    n = ~r;
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      (r == 4'b1110): idx = 2'd0;
      (r == 4'b1101): idx = 2'd1;
      (r == 4'b1011): idx = 2'd2;
      (r == 4'b0111): idx = 2'd3;
      default:        idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_lookup(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return KEYMAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_event_queue_fifo.sv
// Small circular queue of key codes with a registered head entry.
// Pointers carry one extra bit so full and empty differ by the MSB.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;
  logic             valid_nxt;
  logic [WIDTH-1:0] head_nxt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_nxt = wr_ptr + (AW+1)'(do_push);
  assign rd_nxt = rd_ptr + (AW+1)'(do_pop);

  assign valid_nxt = (wr_nxt != rd_nxt);

  // The next head may be the slot being written in this very cycle
  always_comb begin
    head_nxt = mem[rd_nxt[AW-1:0]];
    if (do_push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
      head_nxt = wdata;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      valid  <= valid_nxt;
      if (valid_nxt)
        head <= head_nxt;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// 4x4 keypad scanner: sync, debounce, encode, and queue key codes
// for the calculator core over a valid/ready handshake.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       drop_pulse,
  output logic       scanning
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  // Rows seen within this many cycles of a column change are stale
  localparam logic [SW-1:0] SETTLE   = SW'(3);
  localparam logic [SW-1:0] SCAN_TOP = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TOP  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [3:0]    cand;
  logic [1:0]    col_idx;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  kp_state_e     state;

  logic          deb_done;
  logic          push;
  logic          pop;
  logic [3:0]    push_code;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  assign deb_done  = (deb_cnt == DEB_TOP);
  assign push      = (state == ST_DEB_PRESS) &&
                     (row_s == cand) && deb_done;
  assign push_code = key_lookup(low_idx(cand), col_idx);
  assign pop       = key_ready && !fifo_empty;
  assign scanning  = (state == ST_SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SCAN;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      col_idx    <= 2'd0;
      col_out    <= 4'b1110;
      cand       <= 4'hF;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= push && fifo_full && !pop;
      case (state)
        ST_SCAN: begin
          if ((scan_cnt >= SETTLE) && one_low(row_s)) begin
            cand    <= row_s;
            deb_cnt <= '0;
            state   <= ST_DEB_PRESS;
          end else if (scan_cnt == SCAN_TOP) begin
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        ST_DEB_PRESS: begin
          if (row_s != cand) begin
            deb_cnt <= '0;
            state   <= ST_SCAN;
          end else if (deb_done) begin
            deb_cnt <= '0;
            state   <= ST_HELD;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        ST_HELD: begin
          if (row_s == 4'hF) begin
            deb_cnt <= '0;
            state   <= ST_DEB_RELEASE;
          end
        end
        ST_DEB_RELEASE: begin
          if (row_s != 4'hF) begin
            deb_cnt <= '0;
            state   <= ST_HELD;
          end else if (deb_done) begin
            deb_cnt  <= '0;
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col_out  <= {col_out[2:0], col_out[3]};
            state    <= ST_SCAN;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_code),
    .pop   (pop),
    .head  (key_code),
    .valid (key_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
